// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default geometry for the OV7670 capture path
package cam_pkg;
   typedef enum logic [1:0] {S_WAIT_CFG, S_SYNC, S_ARMED, S_CAPTURE} cap_state_t;
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;
   localparam int CAM_H_ACTIVE = 640;
   localparam int CAM_V_ACTIVE = 480;
endpackage

// File: rtl/cdc_sync.sv
// cdc_sync: N-flop synchronizer for a W-bit bundle of asynchronous inputs
module cdc_sync #(
   parameter int W = 1,
   parameter int N = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [N-1:0][W-1:0] sync_q;
   // shift the raw input through N flops
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sync_q <= '0;
      else sync_q <= {sync_q[N-2:0], d_i};
   assign q_o = sync_q[N-1];
endmodule

// File: rtl/ov7670_capture.sv
// ov7670_capture: aligns to OV7670 frame timing and emits addressed RGB565 pixels
module ov7670_capture
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = CAM_H_ACTIVE,
   parameter int V_ACTIVE = CAM_V_ACTIVE,
   parameter int ADDR_W   = 19
) (
   input  logic              xclk,
   input  logic              reset_n,
   input  logic              cfg_done,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_d,
   output logic              pix_valid,
   output logic [15:0]       pix_data,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              frame_start,
   output logic              frame_done,
   output logic              frame_err
);
   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int RW = $clog2(V_ACTIVE + 1);
   localparam logic [CW-1:0]     COL_MAX   = CW'(H_ACTIVE);
   localparam logic [RW-1:0]     ROW_MAX   = RW'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W:0]   FRAME_PIX = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

   logic [2:0] ctrl_s;
   logic [7:0] d_s;
   logic pclk_s, vsync_s, href_s;
   logic pclk_h_q, vsync_h_q, href_h_q;
   logic pclk_rise, vs_rise, vs_fall, href_fall;
   cap_state_t state_q, state_d;
   logic start_go, done_go, cap_en, emit;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic phase_q, phase_d, ovf_q, ovf_d;
   logic [7:0] hi_q, hi_d;
   logic [ADDR_W:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, pix_addr_q;
   rgb565_t pix_data_q;
   logic pix_valid_q, frame_start_q, frame_done_q, frame_err_q;

   cdc_sync #(.W(3)) u_ctrl_sync (
      .clk_i(xclk), .rst_ni(reset_n), .d_i({cam_pclk, cam_vsync, cam_href}), .q_o(ctrl_s)
   );
   cdc_sync #(.W(8)) u_data_sync (
      .clk_i(xclk), .rst_ni(reset_n), .d_i(cam_d), .q_o(d_s)
   );
   assign {pclk_s, vsync_s, href_s} = ctrl_s;

   // one-cycle history of the synced controls for edge detection
   always_ff @(posedge xclk or negedge reset_n)
      if (!reset_n) {pclk_h_q, vsync_h_q, href_h_q} <= '0;
      else {pclk_h_q, vsync_h_q, href_h_q} <= ctrl_s;

   assign pclk_rise = pclk_s & ~pclk_h_q;
   assign vs_rise   = vsync_s & ~vsync_h_q;
   assign vs_fall   = ~vsync_s & vsync_h_q;
   assign href_fall = ~href_s & href_h_q;

   // capture state register
   always_ff @(posedge xclk or negedge reset_n)
      if (!reset_n) state_q <= S_WAIT_CFG;
      else state_q <= state_d;

   // capture state transitions
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT_CFG: if (cfg_done) state_d = S_SYNC;
         S_SYNC:     if (vsync_s) state_d = S_ARMED;
         S_ARMED:    if (vs_fall) state_d = S_CAPTURE;
         S_CAPTURE:  if (vs_rise) state_d = S_ARMED;
         default:    state_d = S_WAIT_CFG;
      endcase
   end

   // per-state action decode
   always_comb begin
      start_go = (state_q == S_ARMED) && vs_fall;
      done_go  = (state_q == S_CAPTURE) && vs_rise;
      cap_en   = (state_q == S_CAPTURE) && !vs_rise;
   end

   // pixel assembly, position tracking and running address
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      phase_d = phase_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      base_d  = base_q;
      ovf_d   = ovf_q;
      emit    = 1'b0;
      if (start_go) begin
         col_d   = '0;
         row_d   = '0;
         phase_d = 1'b0;
         cnt_d   = '0;
         addr_d  = '0;
         base_d  = '0;
         ovf_d   = 1'b0;
      end else if (cap_en && href_fall) begin
         phase_d = 1'b0;
         col_d   = '0;
         if (col_q != '0 && row_q != ROW_MAX) begin
            row_d  = row_q + 1'b1;
            base_d = base_q + H_STEP;
            addr_d = base_q + H_STEP;
         end
      end else if (cap_en && pclk_rise && href_s) begin
         phase_d = ~phase_q;
         if (!phase_q) hi_d = d_s;
         else begin
            emit  = (col_q != COL_MAX) && (row_q != ROW_MAX);
            ovf_d = ovf_q | ~emit;
            cnt_d = emit ? cnt_q + 1'b1 : cnt_q;
            addr_d = emit ? addr_q + 1'b1 : addr_q;
            col_d = (col_q != COL_MAX) ? col_q + 1'b1 : col_q;
         end
      end
   end

   // datapath state and registered outputs
   always_ff @(posedge xclk or negedge reset_n)
      if (!reset_n) begin
         col_q         <= '0;
         row_q         <= '0;
         phase_q       <= 1'b0;
         hi_q          <= '0;
         cnt_q         <= '0;
         addr_q        <= '0;
         base_q        <= '0;
         ovf_q         <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_data_q    <= '0;
         pix_addr_q    <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         phase_q       <= phase_d;
         hi_q          <= hi_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         base_q        <= base_d;
         ovf_q         <= ovf_d;
         pix_valid_q   <= emit;
         pix_data_q    <= emit ? rgb565_t'({hi_q, d_s}) : pix_data_q;
         pix_addr_q    <= emit ? addr_q : pix_addr_q;
         frame_start_q <= start_go;
         frame_done_q  <= done_go;
         frame_err_q   <= done_go && (ovf_q || cnt_q != FRAME_PIX);
      end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_addr    = pix_addr_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: randomized frame stimulus checked against a line/byte-level capture model
module tb_ov7670_capture;
   localparam int H = 4, V = 2, AW = 3;
   logic xclk = 0, reset_n = 0, cfg_done = 0;
   logic cam_pclk = 0, cam_vsync = 0, cam_href = 0;
   logic [7:0] cam_d = 0;
   logic pix_valid, frame_start, frame_done, frame_err;
   logic [15:0] pix_data;
   logic [AW-1:0] pix_addr;
   int total = 0, bad = 0;
   logic [15:0] exp_d[$], obs_d[$];
   logic [AW-1:0] exp_a[$], obs_a[$];
   logic exp_err[$], obs_err[$];
   int starts_seen = 0, exp_starts = 0, hp = 20, nl = 0;
   int lens[4];
   logic [7:0] fb[4][16];
   bit pat = 0;
   longint cyc = 0, last_pv = -100;

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .xclk(xclk), .reset_n(reset_n), .cfg_done(cfg_done),
      .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_addr(pix_addr),
      .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 xclk = ~xclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   always @(negedge xclk) begin
      cyc++;
      if (pix_valid) begin
         check("pix_with_start", 32'(frame_start), 0);
         check("pix_gap_ge8", 32'(cyc - last_pv >= 8), 1);
         last_pv = cyc;
         if (exp_d.size() == 0) fail("pix_unexpected");
         else begin
            check("pix_data", 32'(pix_data), 32'(exp_d.pop_front()));
            check("pix_addr", 32'(pix_addr), 32'(exp_a.pop_front()));
         end
         obs_d.push_back(pix_data);
         obs_a.push_back(pix_addr);
      end
      if (frame_start) starts_seen++;
      if (frame_done) begin
         obs_err.push_back(frame_err);
         if (exp_err.size() == 0) fail("done_unexpected");
         else check("frame_err", 32'(frame_err), 32'(exp_err.pop_front()));
      end
   end

   task automatic cam_cycle(input logic v, input logic h, input logic [7:0] b);
      cam_pclk = 0;
      cam_vsync = v;
      cam_href = h;
      cam_d = b;
      #(hp);
      cam_pclk = 1;
      #(hp);
   endtask

   task automatic drive_frame(input bit cap);
      logic [7:0] pv[4];
      int r, kept, o;
      bit ovf;
      pv = '{8'hF8, 8'h00, 8'h07, 8'hE0};
      for (int l = 0; l < nl; l++)
         for (int i = 0; i < lens[l]; i++) fb[l][i] = pat ? pv[i % 4] : 8'($urandom);
      if (cap) begin
         r = 0;
         kept = 0;
         ovf = 0;
         for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < lens[l] / 2; k++)
               if (k < H && r < V) begin
                  exp_d.push_back({fb[l][2*k], fb[l][2*k+1]});
                  exp_a.push_back(AW'(r * H + k));
                  kept++;
               end else ovf = 1;
            if (lens[l] / 2 > 0) r++;
         end
         exp_err.push_back(ovf || kept != H * V);
         exp_starts++;
      end
      o = $urandom_range(0, 8);
      o = (o >= 5) ? o + 1 : o;
      @(negedge xclk);
      #(o);
      repeat (3) cam_cycle(1, 0, 0);
      repeat (2) cam_cycle(0, 0, 0);
      for (int l = 0; l < nl; l++) begin
         for (int i = 0; i < lens[l]; i++) cam_cycle(0, 1, fb[l][i]);
         if (lens[l] > 0) repeat (3) cam_cycle(0, 0, 0);
      end
      repeat (2) cam_cycle(0, 0, 0);
   endtask

   task automatic set_lines(input int n, input int a, input int b);
      nl = n;
      lens[0] = a;
      lens[1] = b;
      lens[2] = 0;
      lens[3] = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #22;
      check("rst_pix_valid", 32'(pix_valid), 0);
      check("rst_pix_data", 32'(pix_data), 0);
      check("rst_pix_addr", 32'(pix_addr), 0);
      check("rst_frame_start", 32'(frame_start), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      #1 reset_n = 1;
      set_lines(2, 8, 8);
      drive_frame(0);
      fork
         drive_frame(0);
         begin #400 cfg_done = 1; end
      join
      check("starts_before_cfg", 32'(starts_seen), 0);
      check("pix_before_cfg", 32'(obs_d.size()), 0);
      pat = 1;
      drive_frame(1);
      pat = 0;
      repeat (10) @(negedge xclk);
      check("pat_count", 32'(obs_d.size()), 8);
      check("pat_d0", 32'(obs_d[0]), 32'h F800);
      check("pat_d1", 32'(obs_d[1]), 32'h 07E0);
      check("pat_d2", 32'(obs_d[2]), 32'h F800);
      check("pat_a0", 32'(obs_a[0]), 0);
      check("pat_a7", 32'(obs_a[7]), 7);
      check("first_start", 32'(starts_seen), 1);
      set_lines(2, 5, 8);
      drive_frame(1);
      set_lines(2, 12, 8);
      drive_frame(1);
      set_lines(2, 8, 8);
      fork
         drive_frame(1);
         begin
            for (int i = 0; i < 3000 && !pix_valid; i++) @(negedge xclk);
            if (!pix_valid) fail("rst_wait_pix_timeout");
            #2 reset_n = 0;
            #1;
            check("midrst_pix_valid", 32'(pix_valid), 0);
            check("midrst_pix_data", 32'(pix_data), 0);
            check("midrst_pix_addr", 32'(pix_addr), 0);
            check("midrst_frame_start", 32'(frame_start), 0);
            check("midrst_frame_done", 32'(frame_done), 0);
            check("midrst_frame_err", 32'(frame_err), 0);
            exp_d.delete();
            exp_a.delete();
            exp_err.delete();
            #20 reset_n = 1;
         end
      join
      drive_frame(1);
      for (int f = 0; f < 16; f++) begin
         hp = ($urandom_range(0, 3) == 0) ? 30 : 20;
         nl = $urandom_range(0, 3);
         for (int l = 0; l < 4; l++) lens[l] = $urandom_range(0, 12);
         drive_frame(1);
      end
      hp = 20;
      @(negedge xclk);
      #1;
      repeat (3) cam_cycle(1, 0, 0);
      repeat (20) @(negedge xclk);
      check("pix_queue_drained", 32'(exp_d.size()), 0);
      check("done_queue_drained", 32'(exp_err.size()), 0);
      check("start_count", 32'(starts_seen), 32'(exp_starts));
      check("err_exact_frame", 32'(obs_err[0]), 0);
      check("err_odd_line", 32'(obs_err[1]), 1);
      check("err_long_line", 32'(obs_err[2]), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
